// File: rtl/cntr8_pkg.sv
// Shared types and constants for the cntr8 PWM generator slice.
// Optional deadband feature is enabled with CNTR8_PWM_DEADBAND_EN.
package cntr8_pkg;

    localparam int CNT_W = 8;

    localparam logic [CNT_W-1:0] DEFAULT_RESET_DUTY = 8'h80;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        APPLY   = 2'd2
    } pwm_state_t;

endpackage

// File: rtl/cntr8_pwm_gen_if.sv
// Duty configuration port: valid/ready offer of a new duty plus a
// status flag telling the producer a duty is waiting for the next wrap.
interface cntr8_pwm_gen_if
    import cntr8_pkg::*;
#(
    parameter int WIDTH = CNT_W
);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_duty;
    logic             cfg_pending;

    modport master (
        output cfg_valid,
        output cfg_duty,
        input  cfg_ready,
        input  cfg_pending
    );

    modport slave (
        input  cfg_valid,
        input  cfg_duty,
        output cfg_ready,
        output cfg_pending
    );

endinterface

// File: rtl/cntr8_deadband.sv
// Splits a raw PWM level into a high-side and low-side drive pair with
// DEADBAND cycles of both-low before either output is allowed to rise.
// Instantiated by cntr8_pwm_gen only under CNTR8_PWM_DEADBAND_EN.
module cntr8_deadband
    import cntr8_pkg::*;
#(
    parameter int DEADBAND = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_raw,
    output logic hi,
    output logic lo
);

    localparam logic [CNT_W-1:0] DB = CNT_W'(DEADBAND);

    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] lo_cnt;

    // High side: drops at once with the raw level, rises only after the delay expires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi     <= 1'b0;
            hi_cnt <= DB;
        end else if (!pwm_raw) begin
            hi     <= 1'b0;
            hi_cnt <= DB;
        end else if (hi_cnt == '0) begin
            hi <= 1'b1;
        end else begin
            hi_cnt <= hi_cnt - 1'b1;
        end
    end

    // Low side: mirror of the high side on the inverted raw level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo     <= 1'b0;
            lo_cnt <= DB;
        end else if (pwm_raw) begin
            lo     <= 1'b0;
            lo_cnt <= DB;
        end else if (lo_cnt == '0) begin
            lo <= 1'b1;
        end else begin
            lo_cnt <= lo_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/cntr8_pwm_gen.sv
// PWM generator fed by the free-running counter. Duty updates are held in a
// shadow register and committed only after a detected wrap, so a period is
// never cut short. Define CNTR8_PWM_DEADBAND_EN for the complementary output
// with dead time.
module cntr8_pwm_gen
    import cntr8_pkg::*;
#(
    parameter int               WIDTH      = CNT_W,
    parameter logic [WIDTH-1:0] RESET_DUTY = WIDTH'(DEFAULT_RESET_DUTY),
    parameter int               DEADBAND   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             cnt_en,
    cntr8_pwm_gen_if.slave   cfg,
    output logic [WIDTH-1:0] duty_active,
    output logic             pwm_out,
    output logic             wrap_pulse,
    output logic             match_pulse
`ifdef CNTR8_PWM_DEADBAND_EN
    ,
    output logic             pwm_n_out
`endif
);

    pwm_state_t       state;
    pwm_state_t       next_state;
    logic [WIDTH-1:0] prev_cnt;
    logic [WIDTH-1:0] shadow;
    logic             pwm_q;
    logic             wrap_det;
    logic             transfer;

    assign wrap_det = cnt_en && (cnt_in < prev_cnt);
    assign transfer = cfg.cfg_valid && cfg.cfg_ready;

    // Sample the counter: wrap detect, compare and match, frozen while cnt_en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_cnt    <= '0;
            pwm_q       <= 1'b0;
            wrap_pulse  <= 1'b0;
            match_pulse <= 1'b0;
        end else begin
            wrap_pulse  <= wrap_det;
            match_pulse <= cnt_en && (cnt_in == duty_active);
            if (cnt_en) begin
                prev_cnt <= cnt_in;
                pwm_q    <= (cnt_in < duty_active);
            end
        end
    end

    // State register; ready/pending are registered decodes of the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cfg.cfg_ready   <= 1'b1;
            cfg.cfg_pending <= 1'b0;
        end else begin
            state           <= next_state;
            cfg.cfg_ready   <= (next_state == IDLE);
            cfg.cfg_pending <= (next_state != IDLE);
        end
    end

    // Next state: accept in IDLE, wait for a wrap in PENDING, commit for one cycle in APPLY.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (transfer) next_state = PENDING;
            PENDING: if (wrap_det) next_state = APPLY;
            APPLY:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Capture the offered duty into the shadow and commit it during APPLY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow      <= '0;
            duty_active <= RESET_DUTY;
        end else begin
            if (transfer) begin
                shadow <= cfg.cfg_duty;
            end
            if (state == APPLY) begin
                duty_active <= shadow;
            end
        end
    end

`ifdef CNTR8_PWM_DEADBAND_EN
    cntr8_deadband #(
        .DEADBAND (DEADBAND)
    ) u_deadband (
        .clk     (clk),
        .rst     (rst),
        .pwm_raw (pwm_q),
        .hi      (pwm_out),
        .lo      (pwm_n_out)
    );
`else
    logic unused_deadband;
    assign unused_deadband = (DEADBAND != 0);
    assign pwm_out = pwm_q;
`endif

endmodule

// File: tb/tb_cntr8_pwm_gen.sv
// Directed testbench for cntr8_pwm_gen: reset state, compare/match/wrap over
// full sweeps, shadowed duty updates, edge duties, cnt_en stalls and reset
// while a duty is pending.
module tb_cntr8_pwm_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cnt_in;
    logic       cnt_en;
    logic [7:0] duty_active;
    logic       pwm_out;
    logic       wrap_pulse;
    logic       match_pulse;
`ifdef CNTR8_PWM_DEADBAND_EN
    logic       pwm_n_out;
`endif

    int vectors     = 0;
    int miscompares = 0;

    cntr8_pwm_gen_if #(.WIDTH(8)) cfg_bus ();

    cntr8_pwm_gen #(
        .WIDTH      (8),
        .RESET_DUTY (8'h80),
        .DEADBAND   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cnt_in      (cnt_in),
        .cnt_en      (cnt_en),
        .cfg         (cfg_bus.slave),
        .duty_active (duty_active),
        .pwm_out     (pwm_out),
        .wrap_pulse  (wrap_pulse),
        .match_pulse (match_pulse)
`ifdef CNTR8_PWM_DEADBAND_EN
        ,
        .pwm_n_out   (pwm_n_out)
`endif
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs and return 1 time unit after the edge that samples them.
    task automatic applyStimulus(input logic [7:0] c, input logic en, input logic v, input logic [7:0] d);
        cnt_in            = c;
        cnt_en            = en;
        cfg_bus.cfg_valid = v;
        cfg_bus.cfg_duty  = d;
        @(posedge clk);
        #1;
    endtask

    // Count through a range with cnt_en high and check compare, match and wrap.
    task automatic sweep(input int from, input int to, input logic [7:0] duty, input bit wrap_at_zero);
        for (int c = from; c <= to; c++) begin
            applyStimulus(8'(c), 1'b1, 1'b0, 8'h00);
            checkOutput("pwm_out", 32'(pwm_out), 32'(c < int'(duty)));
            checkOutput("match_pulse", 32'(match_pulse), 32'(c == int'(duty)));
            checkOutput("wrap_pulse", 32'(wrap_pulse), 32'((c == 0) && wrap_at_zero));
        end
    endtask

    // Check the configuration side state in one call.
    task automatic checkCfg(input string tag, input logic [7:0] duty, input logic ready, input logic pending);
        checkOutput({tag, "_duty"}, 32'(duty_active), 32'(duty));
        checkOutput({tag, "_ready"}, 32'(cfg_bus.cfg_ready), 32'(ready));
        checkOutput({tag, "_pending"}, 32'(cfg_bus.cfg_pending), 32'(pending));
    endtask

`ifdef CNTR8_PWM_DEADBAND_EN
    // The two drive outputs must never be high together.
    always @(negedge clk) begin
        if (!rst) checkOutput("no_overlap", 32'(pwm_out & pwm_n_out), 32'd0);
    end
`endif

    // Directed sequence of scenarios.
    initial begin
        rst               = 1'b1;
        cnt_in            = 8'h00;
        cnt_en            = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_duty  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checkCfg("reset", 8'h80, 1'b1, 1'b0);
        checkOutput("reset_pwm", 32'(pwm_out), 32'd0);
        checkOutput("reset_wrap", 32'(wrap_pulse), 32'd0);
        checkOutput("reset_match", 32'(match_pulse), 32'd0);
        rst = 1'b0;

        $display("[TB] full sweep at reset duty");
        sweep(0, 255, 8'h80, 1'b0);
        sweep(0, 99, 8'h80, 1'b1);

        $display("[TB] duty 0x40 offered mid-period");
        applyStimulus(8'd100, 1'b1, 1'b1, 8'h40);
        checkCfg("xfer", 8'h80, 1'b0, 1'b1);
        applyStimulus(8'd101, 1'b1, 1'b1, 8'h22);
        checkCfg("ignored", 8'h80, 1'b0, 1'b1);
        sweep(102, 255, 8'h80, 1'b0);
        checkCfg("pre_wrap", 8'h80, 1'b0, 1'b1);
        applyStimulus(8'd0, 1'b1, 1'b0, 8'h00);
        checkOutput("wrap1", 32'(wrap_pulse), 32'd1);
        checkOutput("wrap1_pwm", 32'(pwm_out), 32'd1);
        checkCfg("apply", 8'h80, 1'b0, 1'b1);
        applyStimulus(8'd1, 1'b1, 1'b0, 8'h00);
        checkCfg("applied", 8'h40, 1'b1, 1'b0);
        checkOutput("applied_pwm", 32'(pwm_out), 32'd1);
        sweep(2, 255, 8'h40, 1'b0);

        $display("[TB] transfer coincident with wrap");
        applyStimulus(8'd0, 1'b1, 1'b1, 8'h10);
        checkOutput("coinc_wrap", 32'(wrap_pulse), 32'd1);
        checkCfg("coinc", 8'h40, 1'b0, 1'b1);
        sweep(1, 255, 8'h40, 1'b0);
        checkCfg("coinc_hold", 8'h40, 1'b0, 1'b1);
        applyStimulus(8'd0, 1'b1, 1'b0, 8'h00);
        checkOutput("coinc_wrap2", 32'(wrap_pulse), 32'd1);
        checkOutput("coinc_duty_old", 32'(duty_active), 32'h40);
        applyStimulus(8'd1, 1'b1, 1'b0, 8'h00);
        checkCfg("coinc_applied", 8'h10, 1'b1, 1'b0);
        checkOutput("coinc_old_cmp", 32'(pwm_out), 32'd1);
        sweep(2, 199, 8'h10, 1'b0);

        $display("[TB] duty 0x00 then 0xFF");
        applyStimulus(8'd200, 1'b1, 1'b1, 8'h00);
        checkOutput("d0_xfer_pwm", 32'(pwm_out), 32'd0);
        sweep(201, 255, 8'h10, 1'b0);
        applyStimulus(8'd0, 1'b1, 1'b0, 8'h00);
        checkOutput("d0_wrap", 32'(wrap_pulse), 32'd1);
        checkOutput("d0_wrap_pwm", 32'(pwm_out), 32'd1);
        applyStimulus(8'd1, 1'b1, 1'b0, 8'h00);
        checkOutput("d0_apply_pwm", 32'(pwm_out), 32'd1);
        checkOutput("d0_duty", 32'(duty_active), 32'h00);
        sweep(2, 255, 8'h00, 1'b0);
        sweep(0, 9, 8'h00, 1'b1);
        applyStimulus(8'd10, 1'b1, 1'b1, 8'hFF);
        checkOutput("dff_xfer_pwm", 32'(pwm_out), 32'd0);
        sweep(11, 255, 8'h00, 1'b0);
        applyStimulus(8'd0, 1'b1, 1'b0, 8'h00);
        checkOutput("dff_wrap", 32'(wrap_pulse), 32'd1);
        checkOutput("dff_wrap_match", 32'(match_pulse), 32'd1);
        checkOutput("dff_wrap_pwm", 32'(pwm_out), 32'd0);
        applyStimulus(8'd1, 1'b1, 1'b0, 8'h00);
        checkOutput("dff_duty", 32'(duty_active), 32'hFF);
        checkOutput("dff_apply_pwm", 32'(pwm_out), 32'd0);
        sweep(2, 255, 8'hFF, 1'b0);
        sweep(0, 49, 8'hFF, 1'b1);

        $display("[TB] cnt_en stall while pending");
        applyStimulus(8'd50, 1'b1, 1'b1, 8'h80);
        checkCfg("stall_xfer", 8'hFF, 1'b0, 1'b1);
        sweep(51, 250, 8'hFF, 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(((i % 2) == 0) ? 8'h00 : 8'hFF, 1'b0, 1'b0, 8'h00);
            checkOutput("stall_wrap", 32'(wrap_pulse), 32'd0);
            checkOutput("stall_match", 32'(match_pulse), 32'd0);
            checkOutput("stall_pwm", 32'(pwm_out), 32'd1);
            checkCfg("stall", 8'hFF, 1'b0, 1'b1);
        end
        sweep(251, 255, 8'hFF, 1'b0);
        applyStimulus(8'd0, 1'b1, 1'b0, 8'h00);
        checkOutput("resume_wrap", 32'(wrap_pulse), 32'd1);
        checkCfg("resume_apply", 8'hFF, 1'b0, 1'b1);
        applyStimulus(8'd1, 1'b1, 1'b0, 8'h00);
        checkCfg("resume_applied", 8'h80, 1'b1, 1'b0);
        sweep(2, 19, 8'h80, 1'b0);

        $display("[TB] reset while pending");
        applyStimulus(8'd20, 1'b1, 1'b1, 8'h10);
        sweep(21, 30, 8'h80, 1'b0);
        checkCfg("pre_rst", 8'h80, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        checkCfg("mid_rst", 8'h80, 1'b1, 1'b0);
        checkOutput("mid_rst_pwm", 32'(pwm_out), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sweep(5, 255, 8'h80, 1'b0);
        applyStimulus(8'd0, 1'b1, 1'b0, 8'h00);
        checkOutput("post_rst_wrap", 32'(wrap_pulse), 32'd1);
        checkCfg("post_rst_wrap", 8'h80, 1'b1, 1'b0);
        applyStimulus(8'd1, 1'b1, 1'b0, 8'h00);
        checkCfg("post_rst_discard", 8'h80, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cntr8_pwm_gen.md
Name: cntr8_pwm_gen

Overview:
- Downstream consumer of the 8-bit free-running counter. Turns the live count value into a registered PWM waveform, a wrap pulse and a compare-match pulse.
- Duty updates arrive over a valid/ready config port. They are held in a shadow register and committed only at counter wrap, so no PWM period is ever truncated or glitched.
- Sits between the counter and the pad/driver logic.

Parameters:
- WIDTH, 8, counter/duty width in bits.
- RESET_DUTY, 8'h80, active duty value after reset.
- DEADBAND, 2, dead-time in clk cycles; used only with the optional feature.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- cnt_in  input  WIDTH  current counter value.
- cnt_en  input  1  cnt_in is valid/advancing this cycle; when low, all sampling logic holds.
- cfg_valid  input  1  new duty offered.
- cfg_ready  output  1  block can accept a duty.
- cfg_duty  input  WIDTH  offered duty value.
- cfg_pending  output  1  shadow duty waiting for wrap.
- duty_active  output  WIDTH  duty currently in use.
- pwm_out  output  1  registered PWM output.
- wrap_pulse  output  1  one-cycle pulse on detected wrap.
- match_pulse  output  1  one-cycle pulse when cnt_in == duty_active.
- pwm_n_out  output  1  complementary output; present only with CNTR8_PWM_DEADBAND_EN.

Behaviour:
- Reset values (async, all outputs and state):
  - duty_active = RESET_DUTY; shadow = 0; prev_cnt = 0.
  - pwm_out = 0; wrap_pulse = 0; match_pulse = 0; cfg_pending = 0; cfg_ready = 1; FSM = IDLE.
- Sampling: only on cycles with cnt_en = 1. prev_cnt <= cnt_in on each sampled cycle.
- Wrap detect: on a sampled cycle with cnt_in < prev_cnt (unsigned), wrap_pulse = 1 on the next cycle.
  - The first sample after reset never flags wrap, because prev_cnt = 0.
- Compare:
  - pwm_out <= (cnt_in < duty_active) on each sampled cycle.
  - Latency: 1 cycle from cnt_in to pwm_out.
  - duty 0 gives constant low. Duty 255 gives low only at count 255.
  - match_pulse <= (cnt_in == duty_active) on sampled cycles; 0 otherwise.
- Handshake:
  - Transfer occurs when cfg_valid && cfg_ready.
  - cfg_ready is a registered function of state: 1 only in IDLE.
  - cfg_duty is sampled into shadow on transfer.
- FSM:
  - IDLE -> PENDING on transfer.
  - PENDING -> APPLY on detected wrap. The detection cycle is the cnt_in < prev_cnt cycle.
  - APPLY -> IDLE after one cycle, with duty_active <= shadow in APPLY.
  - cfg_pending = 1 in PENDING and APPLY.
- Simultaneous events:
  - A transfer in the same cycle as a wrap detect still enters PENDING. The duty applies at the following wrap, not the current one.
  - The compare in the APPLY cycle uses the old duty; the new duty takes effect from the next sampled count.
  - Wrap while in IDLE updates only wrap_pulse.
- cnt_en low in PENDING: the FSM waits indefinitely; no timeout.
- Reset mid-operation: a pending shadow is discarded and the duty returns to RESET_DUTY.
- cfg_duty may change while cfg_ready = 0; it is ignored.

Optional Feature:
- Macro: CNTR8_PWM_DEADBAND_EN.
- Defined:
  - Adds pwm_n_out, the complement of pwm_out.
  - Each rising edge of either output is delayed DEADBAND clk cycles after the other output falls, using a down-counter per edge.
  - Both outputs are 0 during deadband and at reset.
  - If a pulse is shorter than DEADBAND, that output stays low for the period.
- Undefined: port pwm_n_out and the deadband logic are absent; pwm_out behaves as above.

Decomposition:
- Package cntr8_pkg:
  - state enum pwm_state_t {IDLE, PENDING, APPLY}.
  - localparam CNT_W = 8.
  - RESET_DUTY default constant.
- Sub-module cntr8_deadband: one instance, compiled only under the macro. Input pwm_raw; outputs hi/lo.
- Wrap/compare/FSM stay in the top.

Test Plan:
- Reset with the counter sweeping 0..255, cnt_en = 1:
  - pwm_out high for cnt_in 0..127 (1-cycle delay).
  - match_pulse at cnt_in = 128.
  - wrap_pulse once per 255->0 transition.
  - No wrap on the first sample.
- cfg_duty = 8'h40 sent mid-period at cnt_in = 100:
  - cfg_ready drops next cycle; cfg_pending = 1.
  - duty_active stays 8'h80 until wrap, then 8'h40.
  - Next period high for counts 0..63.
  - cfg_ready returns 1 two cycles after the wrap.
- Transfer in the same cycle as the 255->0 wrap: duty applies only at the second wrap.
- Duty 0 gives pwm_out constant 0. Duty 8'hFF gives pwm_out low only at count 255.
- cnt_en held low for 20 cycles during PENDING:
  - All outputs frozen; no wrap.
  - After resume, apply on the next wrap.
- Assert rst while PENDING with shadow 8'h10:
  - Immediate return to duty_active = 8'h80, cfg_ready = 1, pwm_out = 0.
- With CNTR8_PWM_DEADBAND_EN and DEADBAND = 2: pwm_out and pwm_n_out are never both 1, with ≥2 cycles of both-low at each transition.
